// File: rtl/jvm_decode_sequencer_pkg.sv
// Shared types and opcode constants for the bytecode fetch/decode sequencer.
package jvm_decode_sequencer_pkg;

  // Sequencer phases: opcode fetch, operand fetch, micro-op chain walk.
  typedef enum logic [1:0] {
    StFetchOp    = 2'd0,
    StFetchParam = 2'd1,
    StIterate    = 2'd2
  } state_e;

  localparam logic [7:0] NopOpcode  = 8'h00;
  localparam logic [7:0] WideOpcode = 8'hC4;

endpackage

// File: rtl/jvm_operand_collector.sv
// Operand byte bank: clears on opcode capture, appends one byte per load, flags the final byte.
module jvm_operand_collector #(
  parameter int unsigned MAX_PARAMS = 4,
  parameter int unsigned LenW       = $clog2(2 * MAX_PARAMS + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      load_i,
  input  logic [7:0]                byte_i,
  input  logic [LenW-1:0]           n_i,
  output logic [16*MAX_PARAMS-1:0]  operands_o,
  output logic [LenW-1:0]           operand_len_o,
  output logic                      done_o
);

  localparam int unsigned NumBytes = 2 * MAX_PARAMS;

  logic [16*MAX_PARAMS-1:0] operands_d, operands_q;
  logic [LenW-1:0]          len_d, len_q;
  logic [LenW-1:0]          len_inc;

  assign len_inc = len_q + LenW'(1);

  // Next-state: clear wins over load; a load writes the byte slot indexed by the current length.
  always_comb begin
    operands_d = operands_q;
    len_d      = len_q;
    if (clear_i) begin
      operands_d = '0;
      len_d      = '0;
    end else if (load_i) begin
      for (int unsigned k = 0; k < NumBytes; k++) begin
        if (len_q == LenW'(k)) begin
          operands_d[8*k +: 8] = byte_i;
        end
      end
      len_d = len_inc;
    end
  end

  // Bank registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      operands_q <= '0;
      len_q      <= '0;
    end else begin
      operands_q <= operands_d;
      len_q      <= len_d;
    end
  end

  assign done_o        = load_i && (len_inc == n_i);
  assign operands_o    = operands_q;
  assign operand_len_o = len_q;

endmodule

// File: rtl/jvm_decode_sequencer.sv
// Bytecode fetch/decode sequencer: owns the bytecode PC, strips NOP/WIDE prefixes, collects
// operands and walks the micro-op address chain under a valid/ready handshake.
module jvm_decode_sequencer
  import jvm_decode_sequencer_pkg::*;
#(
  parameter int unsigned    PC_W       = 16,
  parameter int unsigned    ADR_W      = 8,
  parameter int unsigned    MAX_PARAMS = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned    CNT_W      = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  output logic [PC_W-1:0]                       iram_addr,
  output logic                                  iram_rd,
  input  logic [7:0]                            iram_data,
  input  logic                                  iram_valid,
  input  logic [$clog2(MAX_PARAMS+1):0]         param_count,
  input  logic                                  pc_load,
  input  logic [PC_W-1:0]                       pc_target,
  input  logic [ADR_W-1:0]                      next_adr,
  output logic [ADR_W-1:0]                      com_adr,
  output logic                                  uop_valid,
  input  logic                                  uop_ready,
  output logic [7:0]                            jvm_opcode,
  output logic                                  is_wide,
  output logic [16*MAX_PARAMS-1:0]              operands,
  output logic [$clog2(2*MAX_PARAMS+1)-1:0]     operand_len,
  output logic                                  len_err,
  output logic [CNT_W-1:0]                      retired
);

  localparam int unsigned PCntW = $clog2(MAX_PARAMS + 1) + 1;
  localparam int unsigned LenW  = $clog2(2 * MAX_PARAMS + 1);
  localparam logic [PCntW-1:0] MaxPcnt = PCntW'(MAX_PARAMS);

  state_e            state_d, state_q;
  logic [PC_W-1:0]   pc_d, pc_q;
  logic [ADR_W-1:0]  com_adr_d, com_adr_q;
  logic [7:0]        opcode_d, opcode_q;
  logic              is_wide_d, is_wide_q;
  logic [LenW-1:0]   n_d, n_q;
  logic              len_err_d, len_err_q;
  logic [CNT_W-1:0]  retired_d, retired_q;

  logic              beat;
  logic              col_clear, col_load, col_done;
  logic              over_limit;
  logic [PCntW-1:0]  base_cnt;
  logic [LenW-1:0]   n_new;

  assign iram_rd = ((state_q == StFetchOp) || (state_q == StFetchParam)) && !pc_load;
  assign beat    = iram_rd && iram_valid;

  // Operand count for a freshly fetched opcode; oversize counts clamp to the legal maximum.
  assign over_limit = param_count > MaxPcnt;
  assign base_cnt   = over_limit ? MaxPcnt : param_count;
  assign n_new      = LenW'(base_cnt) << is_wide_q;

  jvm_operand_collector #(
    .MAX_PARAMS (MAX_PARAMS),
    .LenW       (LenW)
  ) u_collector (
    .clk_i         (clk),
    .rst_i         (reset),
    .clear_i       (col_clear),
    .load_i        (col_load),
    .byte_i        (iram_data),
    .n_i           (n_q),
    .operands_o    (operands),
    .operand_len_o (operand_len),
    .done_o        (col_done)
  );

  // Next-state and datapath control; a redirect overrides the state and PC last.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    com_adr_d = com_adr_q;
    opcode_d  = opcode_q;
    is_wide_d = is_wide_q;
    n_d       = n_q;
    len_err_d = len_err_q;
    retired_d = retired_q;
    col_clear = 1'b0;
    col_load  = 1'b0;

    unique case (state_q)
      StFetchOp: begin
        if (beat) begin
          pc_d = pc_q + PC_W'(1);
          if (iram_data == NopOpcode) begin
            // Prefix-free filler: consume and stay.
          end else if (iram_data == WideOpcode) begin
            is_wide_d = 1'b1;
          end else begin
            opcode_d  = iram_data;
            col_clear = 1'b1;
            n_d       = n_new;
            if (over_limit) begin
              len_err_d = 1'b1;
            end
            if (n_new == '0) begin
              state_d   = StIterate;
              com_adr_d = ADR_W'(iram_data);
            end else begin
              state_d = StFetchParam;
            end
          end
        end
      end
      StFetchParam: begin
        if (beat) begin
          col_load = 1'b1;
          pc_d     = pc_q + PC_W'(1);
          if (col_done) begin
            state_d   = StIterate;
            com_adr_d = ADR_W'(opcode_q);
          end
        end
      end
      StIterate: begin
        if (uop_ready) begin
          if (next_adr == '0) begin
            is_wide_d = 1'b0;
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetchOp;
          end else begin
            com_adr_d = next_adr;
          end
        end
      end
      default: state_d = StFetchOp;
    endcase

    if (pc_load) begin
      pc_d      = pc_target;
      is_wide_d = 1'b0;
      state_d   = StFetchOp;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetchOp;
      pc_q      <= RESET_PC;
      com_adr_q <= '0;
      opcode_q  <= '0;
      is_wide_q <= 1'b0;
      n_q       <= '0;
      len_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      com_adr_q <= com_adr_d;
      opcode_q  <= opcode_d;
      is_wide_q <= is_wide_d;
      n_q       <= n_d;
      len_err_q <= len_err_d;
      retired_q <= retired_d;
    end
  end

  assign iram_addr  = pc_q;
  assign com_adr    = com_adr_q;
  assign uop_valid  = (state_q == StIterate);
  assign jvm_opcode = opcode_q;
  assign is_wide    = is_wide_q;
  assign len_err    = len_err_q;
  assign retired    = retired_q;

endmodule
